bs_gnrtr_n_rbtr: RTL and testbench

BS_GNRTR_N_RBTR -- requirements
Module: bs_gnrtr_n_rbtr

---
 rtl/bs_gnrtr_n_rbtr_pkg.sv | 11 +
 rtl/bs_gnrtr_n_rbtr_rr_arbiter.sv | 25 ++
 rtl/bs_gnrtr_n_rbtr.sv | 85 ++++++++
 tb/tb_bs_gnrtr_n_rbtr.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bs_gnrtr_n_rbtr_pkg.sv
// Shared constants and FSM state type for the bus generator/arbiter.
package bs_gnrtr_n_rbtr_pkg;
    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        PUSH
    } state_t;
endpackage

// File: rtl/bs_gnrtr_n_rbtr_rr_arbiter.sv
// Round-robin selector: lowest requester strictly above the last grant wins,
// otherwise wrap around to the lowest requester overall.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] gnt,
    output logic         valid
);
    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] above;
    logic [N-1:0] hi_req;

    always_comb begin
        // above = every bit strictly more significant than the one-hot last grant
        above  = ~(last | (last - ONE));
        hi_req = req & above;
        if (|hi_req) gnt = hi_req & (~hi_req + ONE);
        else         gnt = req & (~req + ONE);
    end

    assign valid = |req;
endmodule

// File: rtl/bs_gnrtr_n_rbtr.sv
// Bus generator and arbiter: pops one device FIFO per transaction and routes
// the packet to one device, all devices but the sender, or nowhere.
module bs_gnrtr_n_rbtr
    import bs_gnrtr_n_rbtr_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = BCAST_ID
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push
);
    // Pointer reset to the top device so the first search begins at device 0.
    localparam logic [drvrs-1:0] LAST_RST = drvrs'(1) << (drvrs - 1);

    state_t             state, state_nxt;
    logic [drvrs-1:0]   gnt, last_gnt, push_nxt;
    logic               gnt_vld;
    logic [pckg_sz-1:0] head, pkt, lane;
    logic [ID_W-1:0]    dest;

    rr_arbiter #(.N(drvrs)) u_arb (
        .req   (pndng),
        .last  (last_gnt),
        .gnt   (gnt),
        .valid (gnt_vld)
    );

    always_comb begin
        head = '0;
        for (int i = 0; i < drvrs; i++)
            if (last_gnt[i]) head = head | D_pop[i];
    end

    assign dest = head[pckg_sz-1 -: ID_W];

    always_comb begin
        state_nxt = state;
        push_nxt  = '0;
        case (state)
            IDLE: if (gnt_vld) state_nxt = POP;
            POP: begin
                state_nxt = PUSH;
                if (dest == broadcast) push_nxt = ~last_gnt;
                else
                    for (int i = 0; i < drvrs; i++)
                        if (int'(dest) == i) push_nxt[i] = 1'b1;
            end
            PUSH:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pop      <= '0;
            push     <= '0;
            last_gnt <= LAST_RST;
            pkt      <= '0;
            lane     <= '0;
        end else begin
            pop  <= (state == IDLE && gnt_vld) ? gnt : '0;
            push <= push_nxt;
            if (state == IDLE && gnt_vld) last_gnt <= gnt;
            if (state == POP)             pkt      <= head;
            // lanes keep the last delivered packet between pushes
            if (|push)                    lane     <= pkt;
        end
    end

    always_comb begin
        for (int i = 0; i < drvrs; i++)
            D_push[i] = (|push) ? pkt : lane;
    end
endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Random and directed checks of bs_gnrtr_n_rbtr against a transaction-level model.
module tb_bs_gnrtr_n_rbtr;
    localparam int N = 4;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        pndng, pop, push;
    logic [N-1:0][W-1:0] d_pop, d_push;

    always #5 clk = ~clk;

    bs_gnrtr_n_rbtr #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (d_pop),
        .pop    (pop),
        .push   (push),
        .D_push (d_push)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: phase 0 waits for a request, 1 is the pop cycle, 2 the push cycle.
    int           m_phase = 0;
    int           m_last  = N - 1;
    int           m_w     = 0;
    logic [N-1:0] m_pop   = '0;
    logic [N-1:0] m_push  = '0;
    logic [W-1:0] m_pkt   = '0;
    logic [W-1:0] m_lane  = '0;

    task automatic model_step();
        int dst;
        if (reset) begin
            m_phase = 0; m_last = N - 1; m_pop = '0; m_push = '0; m_lane = '0;
            return;
        end
        case (m_phase)
            0: begin
                m_push = '0;
                m_pop  = '0;
                if (pndng != '0) begin
                    for (int k = N; k >= 1; k--)
                        if (pndng[(m_last + k) % N]) m_w = (m_last + k) % N;
                    m_last  = m_w;
                    m_pop   = N'(1) << m_w;
                    m_phase = 1;
                end
            end
            1: begin
                m_pkt = d_pop[m_w];
                m_pop = '0;
                dst   = int'(m_pkt[W-1 -: 8]);
                if (dst == 255)   m_push = {N{1'b1}} ^ (N'(1) << m_w);
                else if (dst < N) m_push = N'(1) << dst;
                else              m_push = '0;
                if (m_push != '0) m_lane = m_pkt;
                m_phase = 2;
            end
            default: begin
                m_push  = '0;
                m_phase = 0;
            end
        endcase
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        chk("pop", 64'(pop), 64'(m_pop));
        chk("push", 64'(push), 64'(m_push));
        for (int i = 0; i < N; i++)
            chk($sformatf("dpush%0d", i), 64'(d_push[i]), 64'(m_lane));
        @(negedge clk);
    endtask

    int gq[$];
    int gc[$];

    initial begin
        reset = 1'b1;
        pndng = '0;
        d_pop = '0;
        @(negedge clk);

        // reset for two cycles
        step();
        step();
        chk("rst_pop", 64'(pop), 64'h0);
        chk("rst_push", 64'(push), 64'h0);
        chk("rst_dpush", 64'(d_push), 64'h0);
        reset = 1'b0;

        // unicast 1 -> 2
        pndng = 4'b0010; d_pop[1] = 16'h02AB;
        step();
        chk("u_pop", 64'(pop), 64'h2);
        pndng = '0;
        step();
        chk("u_push", 64'(push), 64'h4);
        chk("u_data", 64'(d_push[2]), 64'h02AB);
        step();
        chk("u_idle_push", 64'(push), 64'h0);

        // broadcast from 0
        pndng = 4'b0001; d_pop[0] = 16'hFF55;
        step();
        chk("b_pop", 64'(pop), 64'h1);
        pndng = '0;
        step();
        chk("b_push", 64'(push), 64'hE);
        chk("b_data", 64'(d_push[3]), 64'hFF55);
        step();

        // round-robin order with all devices pending, all to ID 0
        reset = 1'b1; step(); reset = 1'b0;
        pndng = 4'b1111;
        for (int i = 0; i < N; i++) d_pop[i] = 16'h0000 | 16'(i);
        gq.delete(); gc.delete();
        for (int i = 0; i < 15; i++) begin
            step();
            if (pop != '0) begin
                for (int b = 0; b < N; b++) if (pop[b]) gq.push_back(b);
                gc.push_back(cyc);
            end
        end
        pndng = '0;
        chk("rr_count", 64'(gq.size()), 64'd5);
        for (int i = 0; i < gq.size() && i < 5; i++) begin
            chk($sformatf("rr_order%0d", i), 64'(gq[i]), 64'(i % N));
            if (i > 0) chk($sformatf("rr_gap%0d", i), 64'(gc[i] - gc[i-1]), 64'd3);
        end
        step(); step();

        // out-of-range destination is dropped
        pndng = 4'b1000; d_pop[3] = 16'h0711;
        step();
        chk("drop_pop", 64'(pop), 64'h8);
        pndng = '0;
        step();
        chk("drop_push", 64'(push), 64'h0);
        step();

        // reset during PUSH aborts and restarts priority at device 0
        pndng = 4'b0100; d_pop[2] = 16'h0399;
        step();
        pndng = '0;
        step();
        chk("abort_pre", 64'(push), 64'h8);
        reset = 1'b1;
        step();
        chk("abort_push", 64'(push), 64'h0);
        reset = 1'b0;
        pndng = 4'b1111;
        step();
        chk("abort_gnt", 64'(pop), 64'h1);
        pndng = '0;
        step(); step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            pndng = N'($urandom);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       d_pop[i][15:8] = 8'($urandom_range(0, N - 1));
                    1:       d_pop[i][15:8] = 8'hFF;
                    2:       d_pop[i][15:8] = 8'($urandom_range(N, 254));
                    default: d_pop[i][15:8] = 8'($urandom);
                endcase
                d_pop[i][7:0] = 8'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
